vip_axi4_checker: RTL and testbench
===================================

VIP_AXI4_CHECKER -- requirements
Module: vip_axi4_checker

Interface
REQ-001 Parameter CFG_P, vip_axi4_cfg_t, '{default:'0}: sets ID, ADDR, DATA, STRB and USER widths.
REQ-002 Parameter WR_CHK_P, 1: enables write-side checking (AW/W/B) when non-zero.
REQ-003 Parameter RD_CHK_P, 1: enables read-side checking (AR/R) when non-zero.
REQ-004 Parameter MAX_OUTST_P, 8: outstanding-burst FIFO depth per direction; power of two, 2..64.
REQ-005 Ports clk and rst_n: one clock; reset is synchronous and active-low.
REQ-006 Inputs awid, awlen, awvalid, awready, awaddr: write-address channel, CFG_P widths.
REQ-007 Inputs wlast, wvalid, wready, wdata, wstrb: write-data channel.
REQ-008 Inputs bid, bvalid, bready: write-response channel.
REQ-009 Inputs arid, arlen, arvalid, arready, araddr: read-address channel.
REQ-010 Inputs rid, rlast, rvalid, rready, rdata: read-data channel.
REQ-011 Input err_clr, 1 bit: clears the sticky error flags and the error counter.
REQ-012 Output err_flags, 12 bits: sticky per-check error flags.
REQ-013 Output err_count, 16 bits: saturating count of error events.
REQ-014 Outputs wr_outst and rd_outst, $clog2(MAX_OUTST_P)+1 bits each: occupancy of the outstanding-burst FIFOs.

Function
REQ-015 A handshake is valid&&ready sampled at a rising clk edge.
REQ-016 Each AW handshake pushes {awid,awlen} into the write FIFO; each AR handshake pushes {arid,arlen} into the read FIFO.
REQ-017 W-beat counter: compares against the head awlen; a beat with beat==awlen pops the head into the B-pending counter and resets the beat count to 0.
REQ-018 Bit0 WLAST_EARLY: set when wlast=1 with beat<awlen.
REQ-019 Bit1 WLAST_MISSING: set when wlast=0 with beat==awlen.
REQ-020 Bit2 W_BEFORE_AW: set on a W handshake while the write FIFO is empty; the beat is discarded (in-house VIP policy).
REQ-021 Bit3 B_UNEXPECTED: set on a B handshake while B-pending==0; otherwise B-pending decrements.
REQ-022 Bit4 B_ID_MISMATCH: set when bid differs from the oldest completed burst ID; completed IDs are held in a FIFO of MAX_OUTST_P entries.
REQ-023 Bits5 RLAST_EARLY, 6 RLAST_MISSING, 7 R_UNEXPECTED: the read FIFO head is checked the same way as W (REQ-017..020); reads are in-order.
REQ-024 Bit8 R_ID_MISMATCH: set when rid differs from the head arid on any R beat.
REQ-025 Bit9 WR_OVERFLOW and bit10 RD_OVERFLOW: set on an AW/AR handshake while the corresponding FIFO is full; the push is dropped.
REQ-026 Bit11 STABILITY: per REQ-032; tied to 0 when the macro is absent.
REQ-027 Flags and counter update one cycle after the offending handshake; err_count adds the number of flags newly asserted in that cycle and saturates at 16'hFFFF.
REQ-028 Simultaneous push and pop on one FIFO (including when full) leave occupancy unchanged and raise no overflow; a full FIFO with a same-cycle pop accepts the push.
REQ-029 err_clr has priority over same-cycle error sets; those events are lost.
REQ-030 With WR_CHK_P=0, bits 0-4 and 9 are held at 0 and wr_outst=0; RD_CHK_P=0 does the same for bits 5-8 and 10, and rd_outst=0.

Reset
REQ-031 On rst_n=0 at a clk edge: both FIFOs empty, beat counters 0, B-pending 0, err_flags=0, err_count=0, wr_outst=0, rd_outst=0; reset mid-burst abandons all tracking with no error.

Configuration
REQ-032 VIP_AXI4_CHK_STABILITY_EN defined: bit11 is set when any of awvalid, wvalid, arvalid, bvalid or rvalid drops, or its payload changes, while valid=1 and ready=0. Undefined: no stability registers are built and bit11=0.

Structure
REQ-033 The error-bit index localparams, the counter width, and the FIFO entry struct {id,len} go in vip_axi4_pkg.
REQ-034 A sub-module vip_axi4_chk_fifo (synchronous FIFO with full/empty/occupancy) is instantiated for the write, completed-ID and read FIFOs.

Verification
REQ-035 AW awlen=3, then 4 W beats with wlast only on the 4th, then B with matching bid -> err_flags=0, wr_outst 1->0.
REQ-036 AR arlen=1, then R beats with rlast=1 on the 1st beat -> bit5 set next cycle, err_count=1.
REQ-037 MAX_OUTST_P=2, three AW handshakes with no W -> bit9 set, wr_outst=2.
REQ-038 B handshake with no prior W burst -> bit3 set; then err_clr=1 -> err_flags=0, err_count=0.
REQ-039 With the macro defined: awvalid=1, awready=0, awaddr changes -> bit11 set; without the macro: bit11 stays 0.
REQ-040 Assert rst_n=0 mid-read burst, then run a fresh legal AR/R burst -> no flags set, rd_outst returns to 0.

Source files
------------

// File: rtl/vip_axi4_pkg.sv
// Shared types, error-bit indices and width helpers for the AXI4 protocol checker.
package vip_axi4_pkg;

  typedef struct packed {
    int unsigned id_w;
    int unsigned addr_w;
    int unsigned data_w;
    int unsigned strb_w;
    int unsigned user_w;
  } vip_axi4_cfg_t;

  localparam int ERR_W            = 12;
  localparam int ERR_WLAST_EARLY  = 0;
  localparam int ERR_WLAST_MISS   = 1;
  localparam int ERR_W_BEFORE_AW  = 2;
  localparam int ERR_B_UNEXPECTED = 3;
  localparam int ERR_B_ID_MISM    = 4;
  localparam int ERR_RLAST_EARLY  = 5;
  localparam int ERR_RLAST_MISS   = 6;
  localparam int ERR_R_UNEXPECTED = 7;
  localparam int ERR_R_ID_MISM    = 8;
  localparam int ERR_WR_OVERFLOW  = 9;
  localparam int ERR_RD_OVERFLOW  = 10;
  localparam int ERR_STABILITY    = 11;

  localparam int CNT_W    = 16;
  localparam int MAX_ID_W = 16;
  localparam int LEN_W    = 8;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [LEN_W-1:0]    len;
  } fifo_entry_t;

  // A zero width in the config selects the default width.
  function automatic int unsigned cfg_w(input int unsigned w, input int unsigned dflt);
    return (w == 0) ? dflt : w;
  endfunction

  function automatic int unsigned min_w(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/vip_axi4_chk_fifo.sv
// Synchronous FIFO with full/empty/occupancy; a pop frees a slot for a same-cycle push.
module vip_axi4_chk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

endmodule

// File: rtl/vip_axi4_checker.sv
// AXI4 protocol checker: burst-length, ordering, ID and overflow checks with sticky flags.
// Optional valid/payload stability checking is built when VIP_AXI4_CHK_STABILITY_EN is defined.
module vip_axi4_checker
  import vip_axi4_pkg::*;
#(
  parameter vip_axi4_cfg_t CFG_P = '{default: '0},
  parameter int WR_CHK_P    = 1,
  parameter int RD_CHK_P    = 1,
  parameter int MAX_OUTST_P = 8,
  localparam int ID_W   = int'(min_w(cfg_w(CFG_P.id_w, 4), MAX_ID_W)),
  localparam int ADDR_W = int'(cfg_w(CFG_P.addr_w, 32)),
  localparam int DATA_W = int'(cfg_w(CFG_P.data_w, 32)),
  localparam int STRB_W = int'(cfg_w(CFG_P.strb_w, DATA_W / 8)),
  localparam int OUT_W  = $clog2(MAX_OUTST_P) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   awid,
  input  logic [LEN_W-1:0]  awlen,
  input  logic              awvalid,
  input  logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wlast,
  input  logic              wvalid,
  input  logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [ID_W-1:0]   bid,
  input  logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [LEN_W-1:0]  arlen,
  input  logic              arvalid,
  input  logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [ID_W-1:0]   rid,
  input  logic              rlast,
  input  logic              rvalid,
  input  logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              err_clr,
  output logic [ERR_W-1:0]  err_flags,
  output logic [CNT_W-1:0]  err_count,
  output logic [OUT_W-1:0]  wr_outst,
  output logic [OUT_W-1:0]  rd_outst
);

  // Bits 0-4,9 belong to the write side, bits 5-8,10 to the read side.
  localparam logic [ERR_W-1:0] WR_BITS  = 12'h21F;
  localparam logic [ERR_W-1:0] RD_BITS  = 12'h5E0;
  localparam logic [ERR_W-1:0] CHK_MASK =
    ~(((WR_CHK_P != 0) ? ERR_W'(0) : WR_BITS) | ((RD_CHK_P != 0) ? ERR_W'(0) : RD_BITS));

  function automatic logic [4:0] ones(input logic [ERR_W-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < ERR_W; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [4:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  fifo_entry_t      wq_din, wq_head, rq_din, rq_head;
  logic             wq_full, wq_empty, wq_pop;
  logic             rq_full, rq_empty, rq_pop;
  logic [OUT_W-1:0] wq_cnt, rq_cnt, cq_cnt;
  logic             cq_full, cq_empty;
  logic [ID_W-1:0]  cq_head;
  logic [LEN_W-1:0] wbeat, rbeat;
  logic             stab_err;
  logic [ERR_W-1:0] err_raw, new_err;

  assign wq_din = '{id: MAX_ID_W'(awid), len: awlen};
  assign rq_din = '{id: MAX_ID_W'(arid), len: arlen};
  assign wq_pop = w_hs && !wq_empty && (wbeat == wq_head.len);
  assign rq_pop = r_hs && !rq_empty && (rbeat == rq_head.len);

  vip_axi4_chk_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(MAX_OUTST_P)) u_wr_fifo (
    .clk(clk), .rst_n(rst_n), .push(aw_hs), .pop(wq_pop), .din(wq_din),
    .dout(wq_head), .full(wq_full), .empty(wq_empty), .count(wq_cnt)
  );

  // Completed write IDs waiting for B; its occupancy is the B-pending count.
  vip_axi4_chk_fifo #(.WIDTH(ID_W), .DEPTH(MAX_OUTST_P)) u_cid_fifo (
    .clk(clk), .rst_n(rst_n), .push(wq_pop), .pop(b_hs), .din(wq_head.id[ID_W-1:0]),
    .dout(cq_head), .full(cq_full), .empty(cq_empty), .count(cq_cnt)
  );

  vip_axi4_chk_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(MAX_OUTST_P)) u_rd_fifo (
    .clk(clk), .rst_n(rst_n), .push(ar_hs), .pop(rq_pop), .din(rq_din),
    .dout(rq_head), .full(rq_full), .empty(rq_empty), .count(rq_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbeat <= '0;
      rbeat <= '0;
    end else begin
      if (wq_pop)                  wbeat <= '0;
      else if (w_hs && !wq_empty)  wbeat <= wbeat + 1'b1;
      if (rq_pop)                  rbeat <= '0;
      else if (r_hs && !rq_empty)  rbeat <= rbeat + 1'b1;
    end
  end

`ifdef VIP_AXI4_CHK_STABILITY_EN
  logic [ID_W+LEN_W+ADDR_W-1:0] aw_pay, aw_pay_p1, ar_pay, ar_pay_p1;
  logic [DATA_W+STRB_W:0]       w_pay, w_pay_p1;
  logic [ID_W+DATA_W:0]         r_pay, r_pay_p1;
  logic [ID_W-1:0]              bid_p1;
  logic [4:0]                   stall_p1;

  assign aw_pay = {awid, awlen, awaddr};
  assign ar_pay = {arid, arlen, araddr};
  assign w_pay  = {wlast, wstrb, wdata};
  assign r_pay  = {rlast, rid, rdata};

  // Pipeline stage p1: previous-cycle stall state and payload of each channel.
  always_ff @(posedge clk) begin
    if (!rst_n) stall_p1 <= '0;
    else stall_p1 <= {awvalid && !awready, wvalid && !wready, bvalid && !bready,
                      arvalid && !arready, rvalid && !rready};
  end

  always_ff @(posedge clk) begin
    aw_pay_p1 <= aw_pay;
    w_pay_p1  <= w_pay;
    bid_p1    <= bid;
    ar_pay_p1 <= ar_pay;
    r_pay_p1  <= r_pay;
  end

  assign stab_err = (stall_p1[4] && (!awvalid || (aw_pay != aw_pay_p1))) ||
                    (stall_p1[3] && (!wvalid  || (w_pay  != w_pay_p1)))  ||
                    (stall_p1[2] && (!bvalid  || (bid    != bid_p1)))    ||
                    (stall_p1[1] && (!arvalid || (ar_pay != ar_pay_p1))) ||
                    (stall_p1[0] && (!rvalid  || (r_pay  != r_pay_p1)));
`else
  logic unused_payload;
  assign unused_payload = ^{awaddr, wdata, wstrb, araddr, rdata};
  assign stab_err = 1'b0;
`endif

  always_comb begin
    err_raw = '0;
    err_raw[ERR_WLAST_EARLY]  = w_hs && !wq_empty && wlast && (wbeat < wq_head.len);
    err_raw[ERR_WLAST_MISS]   = w_hs && !wq_empty && !wlast && (wbeat == wq_head.len);
    err_raw[ERR_W_BEFORE_AW]  = w_hs && wq_empty;
    err_raw[ERR_B_UNEXPECTED] = b_hs && cq_empty;
    err_raw[ERR_B_ID_MISM]    = b_hs && !cq_empty && (bid != cq_head);
    err_raw[ERR_RLAST_EARLY]  = r_hs && !rq_empty && rlast && (rbeat < rq_head.len);
    err_raw[ERR_RLAST_MISS]   = r_hs && !rq_empty && !rlast && (rbeat == rq_head.len);
    err_raw[ERR_R_UNEXPECTED] = r_hs && rq_empty;
    err_raw[ERR_R_ID_MISM]    = r_hs && !rq_empty && (rid != rq_head.id[ID_W-1:0]);
    err_raw[ERR_WR_OVERFLOW]  = aw_hs && wq_full && !wq_pop;
    err_raw[ERR_RD_OVERFLOW]  = ar_hs && rq_full && !rq_pop;
    err_raw[ERR_STABILITY]    = stab_err;
  end

  assign new_err = err_raw & CHK_MASK;

  // Clear wins over any error raised in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) begin
      err_flags <= '0;
      err_count <= '0;
    end else begin
      err_flags <= err_flags | new_err;
      err_count <= sat_add(err_count, ones(new_err));
    end
  end

  assign wr_outst = (WR_CHK_P != 0) ? wq_cnt : '0;
  assign rd_outst = (RD_CHK_P != 0) ? rq_cnt : '0;

  logic unused_status;
  assign unused_status = ^{cq_full, cq_cnt};

endmodule

// File: tb/tb_vip_axi4_checker.sv
// Directed self-checking bench for vip_axi4_checker (MAX_OUTST_P=2, default widths).
module tb_vip_axi4_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awid, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready, err_clr;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  wstrb;
  logic [11:0] err_flags;
  logic [15:0] err_count;
  logic [1:0]  wr_outst, rd_outst;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vip_axi4_checker #(.MAX_OUTST_P(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bid(bid), .bvalid(bvalid), .bready(bready),
    .arid(arid), .arlen(arlen), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .err_clr(err_clr), .err_flags(err_flags), .err_count(err_count),
    .wr_outst(wr_outst), .rd_outst(rd_outst)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic aw(input logic [3:0] id, input logic [7:0] len);
    awid = id; awlen = len; awvalid = 1'b1; awready = 1'b1;
    step();
    awvalid = 1'b0; awready = 1'b0;
  endtask

  task automatic wbeat(input logic last);
    wlast = last; wvalid = 1'b1; wready = 1'b1; wdata = wdata + 32'h11;
    step();
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
  endtask

  task automatic bresp(input logic [3:0] id);
    bid = id; bvalid = 1'b1; bready = 1'b1;
    step();
    bvalid = 1'b0; bready = 1'b0;
  endtask

  task automatic ar(input logic [3:0] id, input logic [7:0] len);
    arid = id; arlen = len; arvalid = 1'b1; arready = 1'b1;
    step();
    arvalid = 1'b0; arready = 1'b0;
  endtask

  task automatic rbeat(input logic [3:0] id, input logic last);
    rid = id; rlast = last; rvalid = 1'b1; rready = 1'b1;
    step();
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
  endtask

  task automatic clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  initial begin
    logic [11:0] stab_exp;
    rst_n = 1'b0; err_clr = 1'b0;
    awid = '0; awlen = '0; awvalid = 1'b0; awready = 1'b0; awaddr = '0;
    wlast = 1'b0; wvalid = 1'b0; wready = 1'b0; wdata = '0; wstrb = 4'hF;
    bid = '0; bvalid = 1'b0; bready = 1'b0;
    arid = '0; arlen = '0; arvalid = 1'b0; arready = 1'b0; araddr = '0;
    rid = '0; rlast = 1'b0; rvalid = 1'b0; rready = 1'b0; rdata = '0;
    step(); step();
    check("rst_flags", 32'(err_flags), 32'h0);
    check("rst_count", 32'(err_count), 32'h0);
    check("rst_wr_outst", 32'(wr_outst), 32'h0);
    check("rst_rd_outst", 32'(rd_outst), 32'h0);
    rst_n = 1'b1;
    step();

    // Legal 4-beat write burst
    aw(4'h1, 8'd3);
    check("wr_outst_after_aw", 32'(wr_outst), 32'h1);
    wbeat(1'b0); wbeat(1'b0); wbeat(1'b0);
    check("wr_mid_burst_flags", 32'(err_flags), 32'h0);
    wbeat(1'b1);
    check("wr_outst_after_last", 32'(wr_outst), 32'h0);
    bresp(4'h1);
    check("wr_legal_flags", 32'(err_flags), 32'h0);
    check("wr_legal_count", 32'(err_count), 32'h0);

    // Early RLAST
    ar(4'h2, 8'd1);
    check("rd_outst_after_ar", 32'(rd_outst), 32'h1);
    rbeat(4'h2, 1'b1);
    check("rlast_early_flags", 32'(err_flags), 32'h020);
    check("rlast_early_count", 32'(err_count), 32'h1);
    rbeat(4'h2, 1'b1);
    check("rd_outst_drained", 32'(rd_outst), 32'h0);
    check("rlast_early_sticky", 32'(err_flags), 32'h020);
    clr();
    check("clr_flags", 32'(err_flags), 32'h0);
    check("clr_count", 32'(err_count), 32'h0);

    // B with nothing pending
    bresp(4'h3);
    check("b_unexp_flags", 32'(err_flags), 32'h008);
    check("b_unexp_count", 32'(err_count), 32'h1);
    clr();
    check("b_unexp_clr_flags", 32'(err_flags), 32'h0);
    check("b_unexp_clr_count", 32'(err_count), 32'h0);

    // Write FIFO overflow at depth 2, then push accepted alongside a pop while full
    aw(4'h0, 8'd0);
    aw(4'h0, 8'd0);
    check("wr_outst_full", 32'(wr_outst), 32'h2);
    aw(4'h0, 8'd0);
    check("wr_ovf_flags", 32'(err_flags), 32'h200);
    check("wr_ovf_outst", 32'(wr_outst), 32'h2);
    check("wr_ovf_count", 32'(err_count), 32'h1);
    awid = 4'h5; awlen = 8'd0; awvalid = 1'b1; awready = 1'b1;
    wlast = 1'b1; wvalid = 1'b1; wready = 1'b1;
    step();
    awvalid = 1'b0; awready = 1'b0; wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    check("full_push_pop_outst", 32'(wr_outst), 32'h2);
    check("full_push_pop_count", 32'(err_count), 32'h1);
    bresp(4'h0);
    wbeat(1'b1);
    bresp(4'h0);
    wbeat(1'b1);
    bresp(4'h5);
    check("wr_drain_outst", 32'(wr_outst), 32'h0);
    check("wr_drain_flags", 32'(err_flags), 32'h200);
    check("wr_drain_count", 32'(err_count), 32'h1);
    clr();

    // B ID mismatch against oldest completed burst
    aw(4'h7, 8'd0);
    wbeat(1'b1);
    bresp(4'h6);
    check("b_id_mism_flags", 32'(err_flags), 32'h010);
    check("b_id_mism_count", 32'(err_count), 32'h1);
    clr();

    // W with no AW outstanding
    wbeat(1'b1);
    check("w_before_aw_flags", 32'(err_flags), 32'h004);
    check("w_before_aw_outst", 32'(wr_outst), 32'h0);
    clr();

    // Missing WLAST on final beat, then early WLAST
    aw(4'h1, 8'd0);
    wbeat(1'b0);
    check("wlast_miss_flags", 32'(err_flags), 32'h002);
    bresp(4'h1);
    check("wlast_miss_b_ok", 32'(err_flags), 32'h002);
    clr();
    aw(4'h1, 8'd1);
    wbeat(1'b1);
    check("wlast_early_flags", 32'(err_flags), 32'h001);
    wbeat(1'b1);
    bresp(4'h1);
    check("wlast_early_done_outst", 32'(wr_outst), 32'h0);
    clr();

    // Read side: R with no AR, then R ID mismatch
    rbeat(4'h1, 1'b1);
    check("r_unexp_flags", 32'(err_flags), 32'h080);
    clr();
    ar(4'h2, 8'd0);
    rbeat(4'h3, 1'b1);
    check("r_id_mism_flags", 32'(err_flags), 32'h100);
    check("r_id_mism_outst", 32'(rd_outst), 32'h0);
    clr();

    // AW held valid without ready while the address changes
`ifdef VIP_AXI4_CHK_STABILITY_EN
    stab_exp = 12'h800;
`else
    stab_exp = 12'h000;
`endif
    awid = 4'h2; awlen = 8'd0; awaddr = 32'h100; awvalid = 1'b1; awready = 1'b0;
    step();
    awaddr = 32'h104;
    step();
    check("stability_flags", 32'(err_flags), 32'(stab_exp));
    check("stability_no_push", 32'(wr_outst), 32'h0);
    awvalid = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    check("stability_clr_flags", 32'(err_flags), 32'h0);

    // Reset mid read burst, then a fresh legal burst
    ar(4'h4, 8'd3);
    rbeat(4'h4, 1'b0);
    rbeat(4'h4, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_rd_outst", 32'(rd_outst), 32'h0);
    check("midrst_flags", 32'(err_flags), 32'h0);
    ar(4'h4, 8'd1);
    rbeat(4'h4, 1'b0);
    rbeat(4'h4, 1'b1);
    check("post_rst_flags", 32'(err_flags), 32'h0);
    check("post_rst_count", 32'(err_count), 32'h0);
    check("post_rst_rd_outst", 32'(rd_outst), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
